// File: rtl/cond_pkg.sv
// Shared constants for the Execute-stage condition unit: condition codes,
// flag bit positions and FlagWrite enable positions.
package cond_pkg;

   localparam int unsigned FLAG_W = 5;
   localparam int unsigned COND_W = 4;

   localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
   localparam logic [COND_W-1:0] COND_NE = 4'b0001;
   localparam logic [COND_W-1:0] COND_CS = 4'b0010;
   localparam logic [COND_W-1:0] COND_CC = 4'b0011;
   localparam logic [COND_W-1:0] COND_MI = 4'b0100;
   localparam logic [COND_W-1:0] COND_PL = 4'b0101;
   localparam logic [COND_W-1:0] COND_VS = 4'b0110;
   localparam logic [COND_W-1:0] COND_VC = 4'b0111;
   localparam logic [COND_W-1:0] COND_HI = 4'b1000;
   localparam logic [COND_W-1:0] COND_LS = 4'b1001;
   localparam logic [COND_W-1:0] COND_GE = 4'b1010;
   localparam logic [COND_W-1:0] COND_LT = 4'b1011;
   localparam logic [COND_W-1:0] COND_GT = 4'b1100;
   localparam logic [COND_W-1:0] COND_LE = 4'b1101;
   localparam logic [COND_W-1:0] COND_AL = 4'b1110;
   localparam logic [COND_W-1:0] COND_NV = 4'b1111;

   localparam int unsigned FLAG_N = 4;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Q = 0;

   localparam int unsigned FW_NZ = 1;
   localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Execute-stage control bundle between the pipeline datapath (master) and
// the condition unit (slave).
interface cond_unit_if;
   import cond_pkg::*;

   logic [COND_W-1:0] CondE;
   logic [FLAG_W-1:0] ALUFlags;
   logic [1:0]        FlagWriteE;
   logic              QWriteE;
   logic              QClrE;
   logic              ValidE;
   logic              StallE;
   logic              RegWriteE;
   logic              MemWriteE;
   logic              PCSrcE;
   logic              CondExE;
   logic              RegWriteGE;
   logic              MemWriteGE;
   logic              PCSrcGE;
   logic [FLAG_W-1:0] FlagsQ;

   modport master (
      output CondE, ALUFlags, FlagWriteE, QWriteE, QClrE, ValidE, StallE,
             RegWriteE, MemWriteE, PCSrcE,
      input  CondExE, RegWriteGE, MemWriteGE, PCSrcGE, FlagsQ
   );

   modport slave (
      input  CondE, ALUFlags, FlagWriteE, QWriteE, QClrE, ValidE, StallE,
             RegWriteE, MemWriteE, PCSrcE,
      output CondExE, RegWriteGE, MemWriteGE, PCSrcGE, FlagsQ
   );

endinterface

// File: rtl/cond_check.sv
// Combinational condition-field evaluator against an NZCV nibble; shared with
// the decode-stage branch predictor.
module cond_check
   import cond_pkg::*;
(
   input  logic [COND_W-1:0] CondE,
   input  logic [3:0]        NZCV,
   output logic              condpass
);

   logic n, z, c, v;

   assign n = NZCV[3];
   assign z = NZCV[2];
   assign c = NZCV[1];
   assign v = NZCV[0];

   always_comb begin
      condpass = 1'b1;
      case (CondE)
         COND_EQ: condpass = z;
         COND_NE: condpass = ~z;
         COND_CS: condpass = c;
         COND_CC: condpass = ~c;
         COND_MI: condpass = n;
         COND_PL: condpass = ~n;
         COND_VS: condpass = v;
         COND_VC: condpass = ~v;
         COND_HI: condpass = c & ~z;
         COND_LS: condpass = ~c | z;
         COND_GE: condpass = (n == v);
         COND_LT: condpass = (n != v);
         COND_GT: condpass = ~z & (n == v);
         COND_LE: condpass = z | (n != v);
         COND_AL: condpass = 1'b1;
         COND_NV: condpass = 1'b1;
         default: condpass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds NZCV plus sticky Q, gates the
// instruction's writes on its condition and commits flags one cycle later.
module cond_unit
   import cond_pkg::*;
(
   input logic         clk,
   input logic         reset,
   cond_unit_if.slave  bus
);

   logic [FLAG_W-1:0] flags_q;
   logic [FLAG_W-1:0] flags_d;
   logic              condpass;
   logic              condex;
   logic              upd;
   logic              q_set;
   logic              q_clr;

   cond_check u_cond_check (
      .CondE    (bus.CondE),
      .NZCV     (flags_q[FLAG_N:FLAG_V]),
      .condpass (condpass)
   );

   assign condex         = condpass & bus.ValidE;
   assign upd            = condex & ~bus.StallE;
   assign bus.CondExE    = condex;
   assign bus.RegWriteGE = bus.RegWriteE & condex;
   assign bus.MemWriteGE = bus.MemWriteE & condex;
   assign bus.PCSrcGE    = bus.PCSrcE & condex;
   assign bus.FlagsQ     = flags_q;

   // Q is sticky: set dominates an explicit clear issued in the same cycle.
   assign q_set = bus.QWriteE & upd & bus.ALUFlags[FLAG_Q];
   assign q_clr = bus.QClrE & upd;

   always_comb begin
      flags_d = flags_q;
      if (upd && bus.FlagWriteE[FW_NZ]) begin
         flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
         flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
      end
      if (upd && bus.FlagWriteE[FW_CV]) begin
         flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
         flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
      end
      if (q_set) begin
         flags_d[FLAG_Q] = 1'b1;
      end else if (q_clr) begin
         flags_d[FLAG_Q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
Execute-stage condition unit at the consuming end of the ALU flag interface. It holds the architectural NZCV flags and the sticky Q flag, and evaluates the 4-bit condition field of the instruction in Execute against the stored flags. It gates that instruction's register, memory and PC writes, and commits new ALU flags at the clock edge when the instruction is allowed to.

Parameters:
- FLAG_W, 5, width of the ALU flag bus {N,Z,C,V,Q}.
- COND_W, 4, width of the condition field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- CondE  in  4  condition field of the Execute instruction.
- ALUFlags  in  5  from ALU: bit4 N, bit3 Z, bit2 C, bit1 V, bit0 Q (overflow|underflow).
- FlagWriteE  in  2  bit1 enables NZ update; bit0 enables CV update.
- QWriteE  in  1  instruction is a saturating op (QADD/QSUB), so Q may be set.
- QClrE  in  1  explicit clear of sticky Q (MSR-style).
- ValidE  in  1  Execute holds a real instruction (0 = bubble/flushed).
- StallE  in  1  Execute held this cycle; no state change.
- RegWriteE  in  1  ungated register write.
- MemWriteE  in  1  ungated memory write.
- PCSrcE  in  1  ungated PC write/branch.
- CondExE  out  1  condition passed and ValidE=1.
- RegWriteGE  out  1  RegWriteE & CondExE.
- MemWriteGE  out  1  MemWriteE & CondExE.
- PCSrcGE  out  1  PCSrcE & CondExE.
- FlagsQ  out  5  registered {N,Z,C,V,Q}.

Behaviour:
- Reset (async, immediate): FlagsQ = 5'b00000. All gated outputs are combinational and follow from the reset flags (e.g. CondE=EQ gives CondExE=0).
- Condition evaluation is combinational on FlagsQ:
  - EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V.
  - HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 treated as 1.
- CondExE = condpass & ValidE. Gated outputs are valid in the same cycle, with zero latency.
- Update at posedge, when upd = CondExE & ~StallE:
  - FlagWriteE[1] & upd: N,Z <= ALUFlags[4:3].
  - FlagWriteE[0] & upd: C,V <= ALUFlags[2:1].
  - Q is sticky. Q <= 1 if QWriteE & upd & ALUFlags[0]. Q <= 0 if QClrE & upd and the set condition does not also hold. Set wins over clear in the same cycle. Otherwise Q holds.
- Write latency is 1 cycle. The instruction in E at cycle t sees flags from instructions committed up to t-1. No internal bypass; the hazard unit stalls if needed.
- StallE=1: all flag state holds. Gated outputs still reflect the current evaluation, and the hazard unit suppresses them downstream.
- ValidE=0: CondExE=0 and all gated writes are 0, regardless of CondE.
- A failed condition gates off both the writes and the flag update, even if FlagWriteE≠0.
- Reset asserted mid-stream clears flags immediately. The first post-reset edge with upd=1 commits normally.

Decomposition:
- Shared package (cond_pkg): condition code localparams (COND_EQ … COND_AL, COND_NV), flag bit indices (FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_Q=0), FlagWrite bit indices.
- One combinational sub-module, cond_check (inputs CondE and NZCV; output condpass), reused by the decode-stage branch predictor.
- Flag registers and Q logic stay in cond_unit.

Test Plan:
- Reset, then CondE=EQ, ValidE=1, RegWriteE=1 -> CondExE=0, RegWriteGE=0, FlagsQ=00000.
- CondE=AL, FlagWriteE=11, ALUFlags=01100 (Z,C) -> next cycle FlagsQ=01100. Then CondE=HI -> CondExE=0; CondE=LS -> CondExE=1; CondE=EQ with MemWriteE=1 -> MemWriteGE=1.
- ALUFlags=10010 (N,V) committed with FlagWriteE=11 -> GE=1, LT=0, GT=1, LE=0. Then FlagWriteE=10 with ALUFlags=01000 -> NZ=01, CV=01 retained, so FlagsQ=01010.
- QWriteE=1, ALUFlags[0]=1, CondE=AL -> FlagsQ[0]=1. Then 5 instructions with ALUFlags[0]=0 -> Q stays 1. QClrE=1 -> Q=0. QClrE=1 with QWriteE=1 and ALUFlags[0]=1 in the same cycle -> Q=1.
- CondE=NE with Z=1, FlagWriteE=11, PCSrcE=1 -> PCSrcGE=0 and flags unchanged. Repeat with StallE=1 and a passing condition -> flags unchanged. Repeat with ValidE=0 -> all gated outputs 0.
- Assert reset asynchronously between edges while FlagsQ=11111 -> FlagsQ=00000 before the next posedge.
